jtpang_objdma: RTL and testbench
================================

// Module: jtpang_objdma
// PURPOSE
// Sequencer for the object-table DMA. On dma_go it requests the CPU bus, walks dma_addr over
// the object area of VRAM and copies each byte read back from VRAM into the object line buffer.
// Sits beside jtpang_char/jtpang_obj in jtpang_video and owns busrq and dma_addr.
// PARAMETERS
// AW   9        address width of dma_addr / buf_addr
// LEN  9'd384   bytes per transfer (1..2**AW); addresses 0..LEN-1
// PORTS
// clk       in   1   system clock (48 MHz)
// rst       in   1   synchronous reset, active high
// cen       in   1   pixel clock enable (pxl_cen, 8 MHz); all sequencing advances on clk&cen
// lvbl      in   1   vertical blank, active low (used only with JTPANG_OBJDMA_VBL_EN)
// dma_go    in   1   start request, sampled every clk (level or pulse)
// busak_n   in   1   bus acknowledge from CPU, active low
// busrq     out  1   bus request to CPU, active high
// dma_addr  out  AW  VRAM read address
// dma_din   in   8   VRAM data; valid one cen after dma_addr changes
// buf_we    out  1   object buffer write strobe, one clk wide, coincident with cen
// buf_addr  out  AW  object buffer write address
// buf_din   out  8   object buffer write data
// busy      out  1   high from request latch until transfer completes
// done      out  1   one-clk pulse after the last buffer write
// BEHAVIOUR
// - Reset: busrq=0, dma_addr=0, buf_we=0, buf_addr=0, buf_din=0, busy=0, done=0, pend=0,
//   state=IDLE. Reset mid-transfer aborts at that edge; busrq low next clk; no done pulse.
// - dma_go sets pend on any clk. Only one start is queued; further starts while pend=1 are lost.
// - IDLE: busrq=0. On cen with pend=1, clear pend, busy=1, dma_addr=0, go REQ.
// - REQ: busrq=1. On cen with busak_n=0, go XFER.
// - XFER: on each cen with busak_n=0, issue dma_addr (read slot).
//   * If dma_addr!=LEN-1: dma_addr<=dma_addr+1.
//   * If dma_addr==LEN-1: hold dma_addr, go FLUSH.
// - Write stage, every state: a read slot issued on cen k is written on cen k+1:
//   buf_we=1, buf_addr=issued address, buf_din=dma_din. No slot issued -> buf_we=0.
//   Exactly LEN writes per transfer; every address written once, in ascending order.
// - Bus loss: busak_n=1 on a XFER cen issues no slot and keeps dma_addr; busrq stays 1.
//   The previous slot's write still completes on that cen. Resumes when busak_n=0.
// - FLUSH: on cen, the last write (LEN-1) happens. Then go IDLE, busrq=0, busy=0,
//   done=1 for that clk. dma_addr returns to 0 on the next IDLE start, not here.
// - pend set during a transfer starts a new transfer from IDLE on the next cen.
//   busrq drops for at least one cen between transfers.
// - LEN=1: REQ->XFER issues addr 0 and goes straight to FLUSH.
// - Counter arithmetic is AW bits; dma_addr never exceeds LEN-1, so it does not wrap.
// CONFIGURATION
// JTPANG_OBJDMA_VBL_EN defined:
//   IDLE->REQ additionally requires lvbl=0. pend stays set until blanking.
//   A transfer still in progress when lvbl rises runs to completion.
// JTPANG_OBJDMA_VBL_EN undefined:
//   lvbl is ignored; the transfer starts on the first cen after dma_go.
// TESTING
// 1 LEN=8; pulse dma_go; busak_n=0 two cens after busrq.
//   -> 8 buf_we with buf_addr 0..7 and buf_din=VRAM[0..7]; then done=1, busrq=0, busy=0.
// 2 LEN=8; hold busak_n=1 for 5 cens after the 3rd slot.
//   -> dma_addr holds at 3, busrq stays 1, no extra writes; resumes and writes 3..7 once each.
// 3 LEN=8; pulse dma_go twice during a transfer.
//   -> exactly one more transfer follows; busrq low >=1 cen between transfers; 16 writes total.
// 4 LEN=8; assert rst while dma_addr=4.
//   -> next clk: busrq=0, busy=0, buf_we=0; no done; a new dma_go restarts from address 0.
// 5 VBL_EN defined; dma_go with lvbl=1.
//   -> busrq stays 0 until lvbl=0; lvbl rising mid-transfer does not abort it; done still pulses.
// 6 Default LEN=384 with real VRAM model.
//   -> 384 writes, last buf_addr=9'd383; done one clk after it; dma_addr never exceeds 383.

Source files
------------

// File: rtl/jtpang_objdma.sv
// Object-table DMA sequencer: requests the CPU bus, reads LEN bytes of VRAM and copies them into the
// object line buffer. Define JTPANG_OBJDMA_VBL_EN to hold transfer starts until vertical blanking.
module jtpang_objdma #(
    parameter int unsigned AW  = 9,
    parameter int unsigned LEN = 384
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          cen,
    input  logic          lvbl,
    input  logic          dma_go,
    input  logic          busak_n,
    output logic          busrq,
    output logic [AW-1:0] dma_addr,
    input  logic [7:0]    dma_din,
    output logic          buf_we,
    output logic [AW-1:0] buf_addr,
    output logic [7:0]    buf_din,
    output logic          busy,
    output logic          done
);

    localparam logic [AW-1:0] LAST = AW'(LEN - 1);

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        XFER,
        FLUSH
    } state_t;

    state_t        state_q, state_d;
    logic          pend_q, pend_d;
    logic          busrq_q, busrq_d;
    logic          busy_q, busy_d;
    logic [AW-1:0] addr_q, addr_d;

    // Read slot issued on one cen, written to the buffer on the next cen.
    logic          slot_vld_q, slot_vld_d;
    logic [AW-1:0] slot_addr_q, slot_addr_d;
    logic [7:0]    slot_data_q, slot_data_d;

    logic          we_q, we_d;
    logic [AW-1:0] baddr_q, baddr_d;
    logic [7:0]    bdin_q, bdin_d;
    logic          fin_q, fin_d;
    logic          done_q, done_d;

    logic          start_ok;

`ifdef JTPANG_OBJDMA_VBL_EN
    assign start_ok = pend_q & ~lvbl;
`else
    logic unused_lvbl;
    assign unused_lvbl = lvbl;
    assign start_ok    = pend_q;
`endif

    always_comb begin
        // NOTE: every next-state signal gets a default here, so no path leaves one unassigned (no latches).
        state_d     = state_q;
        pend_d      = pend_q | dma_go;
        busrq_d     = busrq_q;
        busy_d      = busy_q;
        addr_d      = addr_q;
        slot_vld_d  = slot_vld_q;
        slot_addr_d = slot_addr_q;
        slot_data_d = slot_data_q;
        we_d        = 1'b0;
        baddr_d     = baddr_q;
        bdin_d      = bdin_q;
        fin_d       = 1'b0;
        done_d      = fin_q;

        if (cen) begin
            // Write stage runs in every state: flush whatever slot the previous cen issued.
            if (slot_vld_q) begin
                we_d    = 1'b1;
                baddr_d = slot_addr_q;
                bdin_d  = slot_data_q;
            end
            slot_vld_d = 1'b0;

            case (state_q)
                IDLE: begin
                    if (start_ok) begin
                        pend_d  = dma_go;
                        busy_d  = 1'b1;
                        busrq_d = 1'b1;
                        addr_d  = '0;
                        state_d = REQ;
                    end
                end
                REQ: begin
                    if (!busak_n) begin
                        state_d = XFER;
                    end
                end
                XFER: begin
                    // Data for the current address has been on the bus for a full cen; capture it now.
                    if (!busak_n) begin
                        slot_vld_d  = 1'b1;
                        slot_addr_d = addr_q;
                        slot_data_d = dma_din;
                        if (addr_q == LAST) begin
                            state_d = FLUSH;
                        end else begin
                            addr_d = addr_q + AW'(1);
                        end
                    end
                end
                FLUSH: begin
                    busrq_d = 1'b0;
                    busy_d  = 1'b0;
                    fin_d   = 1'b1;
                    state_d = IDLE;
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            // NOTE: non-blocking assignments keep every register sampling pre-edge values.
            state_q     <= IDLE;
            pend_q      <= 1'b0;
            busrq_q     <= 1'b0;
            busy_q      <= 1'b0;
            addr_q      <= '0;
            slot_vld_q  <= 1'b0;
            slot_addr_q <= '0;
            slot_data_q <= '0;
            we_q        <= 1'b0;
            baddr_q     <= '0;
            bdin_q      <= '0;
            fin_q       <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            pend_q      <= pend_d;
            busrq_q     <= busrq_d;
            busy_q      <= busy_d;
            addr_q      <= addr_d;
            slot_vld_q  <= slot_vld_d;
            slot_addr_q <= slot_addr_d;
            slot_data_q <= slot_data_d;
            we_q        <= we_d;
            baddr_q     <= baddr_d;
            bdin_q      <= bdin_d;
            fin_q       <= fin_d;
            done_q      <= done_d;
        end
    end

    assign busrq    = busrq_q;
    assign dma_addr = addr_q;
    assign buf_we   = we_q;
    assign buf_addr = baddr_q;
    assign buf_din  = bdin_q;
    assign busy     = busy_q;
    assign done     = done_q;

endmodule

// File: tb/tb_jtpang_objdma.sv
// Self-checking bench for jtpang_objdma: an 8-byte instance and a default 384-byte instance share
// one VRAM model; every buffer write is checked against VRAM contents and ascending address order.
module tb_jtpang_objdma;

    localparam int AW = 9;
    localparam int NI = 2;

    logic          clk = 1'b0;
    logic          rst;
    logic          cen;
    logic          last_cen;
    logic          lvbl;
    logic          go       [NI];
    logic          busak_n  [NI];
    logic          busrq    [NI];
    logic [AW-1:0] dma_addr [NI];
    logic [7:0]    dma_din  [NI];
    logic          buf_we   [NI];
    logic [AW-1:0] buf_addr [NI];
    logic [7:0]    buf_din  [NI];
    logic          busy     [NI];
    logic          done     [NI];

    logic [7:0]    vram [512];

    int n_cmp = 0;
    int n_bad = 0;

    // Bus-master model state and monitor state, one slot per instance.
    int   gdly [NI];
    int   gcnt [NI];
    int   lost [NI];
    int   loss_pct [NI];
    int   arm_addr [NI];
    int   div;
    int   exp_nx [NI];
    int   n_wr [NI];
    int   n_done [NI];
    int   max_addr [NI];
    int   last_wr [NI];
    logic done_due [NI];
    logic prev_we [NI];

    always #5 clk = ~clk;

    jtpang_objdma #(.AW(AW), .LEN(8)) u_small (
        .clk(clk), .rst(rst), .cen(cen), .lvbl(lvbl), .dma_go(go[0]), .busak_n(busak_n[0]),
        .busrq(busrq[0]), .dma_addr(dma_addr[0]), .dma_din(dma_din[0]), .buf_we(buf_we[0]),
        .buf_addr(buf_addr[0]), .buf_din(buf_din[0]), .busy(busy[0]), .done(done[0])
    );

    jtpang_objdma #(.AW(AW)) u_big (
        .clk(clk), .rst(rst), .cen(cen), .lvbl(lvbl), .dma_go(go[1]), .busak_n(busak_n[1]),
        .busrq(busrq[1]), .dma_addr(dma_addr[1]), .dma_din(dma_din[1]), .buf_we(buf_we[1]),
        .buf_addr(buf_addr[1]), .buf_din(buf_din[1]), .busy(busy[1]), .done(done[1])
    );

    function automatic int len_of(input int i);
        return (i == 0) ? 8 : 384;
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    always @(posedge clk) last_cen <= cen;

    // Stimulus side: cen divider (48/8 MHz), VRAM read port and CPU bus-grant model.
    always @(negedge clk) begin
        for (int i = 0; i < NI; i++) begin
            dma_din[i] = vram[dma_addr[i]];
            if (last_cen === 1'b1) begin
                if (busrq[i] !== 1'b1) begin
                    busak_n[i] = 1'b1;
                    gcnt[i]    = 0;
                    lost[i]    = 0;
                end else begin
                    if (arm_addr[i] >= 0 && !busak_n[i] && int'(dma_addr[i]) == arm_addr[i]) begin
                        lost[i]     = 5;
                        arm_addr[i] = -1;
                    end
                    if (lost[i] > 0) begin
                        busak_n[i] = 1'b1;
                        lost[i]--;
                    end else if (gcnt[i] < gdly[i]) begin
                        busak_n[i] = 1'b1;
                        gcnt[i]++;
                    end else if (!busak_n[i] && $urandom_range(99) < loss_pct[i]) begin
                        busak_n[i] = 1'b1;
                        lost[i]    = $urandom_range(2);
                    end else begin
                        busak_n[i] = 1'b0;
                    end
                end
            end
        end
        div = (div == 5) ? 0 : div + 1;
        cen = (div == 0);
    end

    // Reference model: each transfer writes addresses 0..LEN-1 in order with VRAM data,
    // one-clk write strobes, and a one-clk done the clk after the final write.
    always @(negedge clk) begin
        for (int i = 0; i < NI; i++) begin
            if (rst) begin
                exp_nx[i]   = 0;
                done_due[i] = 1'b0;
                prev_we[i]  = 1'b0;
            end else begin
                if (int'(dma_addr[i]) > max_addr[i]) max_addr[i] = int'(dma_addr[i]);
                if (done_due[i] || done[i] !== 1'b0) begin
                    check($sformatf("i%0d_done_timing", i), done[i], done_due[i]);
                    if (done[i] === 1'b1) begin
                        n_done[i]++;
                        check($sformatf("i%0d_done_busrq", i), busrq[i], 0);
                        check($sformatf("i%0d_done_busy", i), busy[i], 0);
                    end
                end
                done_due[i] = 1'b0;
                if (prev_we[i]) check($sformatf("i%0d_we_width", i), buf_we[i], 0);
                if (buf_we[i] === 1'b1) begin
                    check($sformatf("i%0d_wr_addr", i), buf_addr[i], exp_nx[i]);
                    check($sformatf("i%0d_wr_data", i), buf_din[i], vram[exp_nx[i]]);
                    n_wr[i]++;
                    last_wr[i] = int'(buf_addr[i]);
                    if (exp_nx[i] == len_of(i) - 1) begin
                        exp_nx[i]   = 0;
                        done_due[i] = 1'b1;
                    end else begin
                        exp_nx[i]++;
                    end
                end
                prev_we[i] = (buf_we[i] === 1'b1);
            end
        end
    end

    task automatic pulse_go(input int i);
        go[i] = 1'b1;
        @(negedge clk);
        go[i] = 1'b0;
    endtask

    task automatic wait_dones(input int i, input int target, input int budget, input string tag);
        int t = 0;
        while (n_done[i] < target && t < budget) begin
            @(negedge clk);
            t++;
        end
        check(tag, n_done[i] >= target, 1);
    endtask

    task automatic refill_vram();
        for (int a = 0; a < 512; a++) vram[a] = 8'($urandom);
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int d, w, t;
        logic moved, rqlow, seen;
        int wins;

        rst  = 1'b1;
        lvbl = 1'b0;
        cen  = 1'b0;
        div  = 0;
        for (int i = 0; i < NI; i++) begin
            go[i] = 1'b0; busak_n[i] = 1'b1; gdly[i] = 2; gcnt[i] = 0; lost[i] = 0;
            loss_pct[i] = 0; arm_addr[i] = -1; exp_nx[i] = 0; n_wr[i] = 0; n_done[i] = 0;
            max_addr[i] = 0; last_wr[i] = -1; done_due[i] = 1'b0; prev_we[i] = 1'b0;
        end
        refill_vram();
        repeat (4) @(negedge clk);

        for (int i = 0; i < NI; i++) begin
            check("rst_busrq", busrq[i], 0);
            check("rst_dma_addr", dma_addr[i], 0);
            check("rst_buf_we", buf_we[i], 0);
            check("rst_buf_addr", buf_addr[i], 0);
            check("rst_buf_din", buf_din[i], 0);
            check("rst_busy", busy[i], 0);
            check("rst_done", done[i], 0);
        end
        rst = 1'b0;
        repeat (3) @(negedge clk);

        // 1: single transfer, grant two cens after request.
        d = n_done[0]; w = n_wr[0];
        pulse_go(0);
        wait_dones(0, d + 1, 2000, "t1_done");
        check("t1_writes", n_wr[0] - w, 8);
        repeat (100) @(negedge clk);
        check("t1_busrq_idle", busrq[0], 0);
        check("t1_no_extra_done", n_done[0], d + 1);

        // 2: bus lost for 5 cens once dma_addr reaches 3.
        d = n_done[0]; w = n_wr[0];
        arm_addr[0] = 3;
        pulse_go(0);
        t = 0;
        while (!(dma_addr[0] == 3 && busak_n[0] === 1'b1) && t < 2000) begin
            @(negedge clk);
            t++;
        end
        check("t2_reach_addr3", t < 2000, 1);
        moved = 1'b0; rqlow = 1'b0; wins = 0;
        repeat (30) begin
            @(negedge clk);
            if (dma_addr[0] != 3) moved = 1'b1;
            if (busrq[0] !== 1'b1) rqlow = 1'b1;
            if (buf_we[0] === 1'b1) wins++;
        end
        check("t2_addr_held", moved, 0);
        check("t2_busrq_held", rqlow, 0);
        check("t2_writes_in_loss", wins, 1);
        wait_dones(0, d + 1, 2000, "t2_done");
        check("t2_writes", n_wr[0] - w, 8);

        // 3: two extra starts during a transfer queue exactly one more transfer.
        d = n_done[0]; w = n_wr[0];
        pulse_go(0);
        t = 0;
        while (busy[0] !== 1'b1 && t < 100) begin
            @(negedge clk);
            t++;
        end
        repeat (20) @(negedge clk);
        pulse_go(0);
        repeat (10) @(negedge clk);
        pulse_go(0);
        wait_dones(0, d + 2, 4000, "t3_done");
        repeat (300) @(negedge clk);
        check("t3_dones", n_done[0] - d, 2);
        check("t3_writes", n_wr[0] - w, 16);

        // 4: reset mid-transfer aborts without done; a new start begins at address 0.
        pulse_go(0);
        t = 0;
        while (dma_addr[0] != 4 && t < 2000) begin
            @(negedge clk);
            t++;
        end
        check("t4_reach_addr4", t < 2000, 1);
        d = n_done[0];
        rst = 1'b1;
        @(negedge clk);
        check("t4_busrq", busrq[0], 0);
        check("t4_busy", busy[0], 0);
        check("t4_buf_we", buf_we[0], 0);
        check("t4_done", done[0], 0);
        @(negedge clk);
        rst = 1'b0;
        repeat (100) @(negedge clk);
        check("t4_no_done", n_done[0], d);
        w = n_wr[0];
        pulse_go(0);
        wait_dones(0, d + 1, 2000, "t4_restart_done");
        check("t4_restart_writes", n_wr[0] - w, 8);

        // Randomized transfers: grant delay, bus loss rate and VRAM contents vary.
        for (int k = 0; k < 12; k++) begin
            gdly[0]     = $urandom_range(0, 4);
            loss_pct[0] = $urandom_range(0, 40);
            refill_vram();
            d = n_done[0]; w = n_wr[0];
            repeat ($urandom_range(1, 7)) @(negedge clk);
            pulse_go(0);
            wait_dones(0, d + 1, 5000, "rnd_done");
            check("rnd_writes", n_wr[0] - w, 8);
        end
        loss_pct[0] = 0;
        gdly[0]     = 2;

        // 5: start gating by vertical blank.
        d = n_done[0]; w = n_wr[0];
`ifdef JTPANG_OBJDMA_VBL_EN
        lvbl = 1'b1;
        pulse_go(0);
        repeat (60) @(negedge clk);
        check("t5_busrq_waits", busrq[0], 0);
        lvbl = 1'b0;
        t = 0;
        while (busrq[0] !== 1'b1 && t < 40) begin
            @(negedge clk);
            t++;
        end
        check("t5_start_in_vbl", t < 40, 1);
        t = 0;
        while (dma_addr[0] != 2 && t < 500) begin
            @(negedge clk);
            t++;
        end
        lvbl = 1'b1;
        wait_dones(0, d + 1, 2000, "t5_done");
        check("t5_writes", n_wr[0] - w, 8);
        lvbl = 1'b0;
`else
        lvbl = 1'b1;
        pulse_go(0);
        seen = 1'b0;
        repeat (40) begin
            @(negedge clk);
            if (busrq[0] === 1'b1) seen = 1'b1;
        end
        check("t5_lvbl_ignored", seen, 1);
        wait_dones(0, d + 1, 2000, "t5_done");
        check("t5_writes", n_wr[0] - w, 8);
        lvbl = 1'b0;
`endif

        // 6: full-length transfer on the default instance with random bus loss.
        refill_vram();
        gdly[1]     = 1;
        loss_pct[1] = 10;
        d = n_done[1]; w = n_wr[1];
        pulse_go(1);
        wait_dones(1, d + 1, 20000, "t6_done");
        check("t6_writes", n_wr[1] - w, 384);
        check("t6_last_addr", last_wr[1], 383);
        check("t6_max_dma_addr", max_addr[1], 383);
        check("t6_small_max_dma_addr", max_addr[0], 7);

        repeat (20) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
